// File: rtl/led_display_sequencer.sv
// LED bank sequencer: an Avalon-MM slave that drives out_port from the CPU data
// register, stretched voice gates, a bouncing scanner or a blinking copy of DATA.
module led_display_sequencer #(
    parameter int                NUM_LEDS   = 14,
    parameter int                RATE_W     = 16,
    parameter logic [RATE_W-1:0] RATE_RESET = 16'd49999,
    parameter int                STRETCH    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] voice_gate,
    output logic [NUM_LEDS-1:0] out_port
);

    localparam int                 POS_W     = $clog2(NUM_LEDS);
    localparam int                 CNT_W     = 4;
    localparam logic [POS_W-1:0]   POS_ZERO  = POS_W'(0);
    localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(NUM_LEDS - 1);
    localparam logic [RATE_W-1:0]  RATE_ZERO = RATE_W'(0);
    localparam logic [RATE_W-1:0]  RATE_ONE  = RATE_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(STRETCH);
    localparam logic [1:0]         MODE_CPU   = 2'd0;
    localparam logic [1:0]         MODE_VOICE = 2'd1;
    localparam logic [1:0]         MODE_SCAN  = 2'd2;
    localparam logic [1:0]         MODE_BLINK = 2'd3;

    typedef enum logic {
        SCAN_UP   = 1'b0,
        SCAN_DOWN = 1'b1
    } scan_dir_e;

    logic [NUM_LEDS-1:0]            data_q, data_d;
    logic [1:0]                     mode_q, mode_d;
    logic [RATE_W-1:0]              rate_q, rate_d;
    logic [RATE_W-1:0]              presc_q, presc_d;
    logic                           tick_q, tick_d;
    logic                           blink_q, blink_d;
    logic [NUM_LEDS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_LEDS-1:0]            out_q, out_d;
    scan_dir_e                      scan_dir_q, scan_dir_d;
    logic [POS_W-1:0]               pos_q, pos_d;

    logic                wr_s, wr_data_s, wr_ctrl_s, wr_rate_s, wr_status_s;
    logic                enter_scan_s, enter_blink_s;
    logic [NUM_LEDS-1:0] lit_s, scan_pat_s;
    logic                unused_wdata_s;

    assign wr_s          = chipselect & ~write_n;
    assign wr_data_s     = wr_s && (address == 2'd0);
    assign wr_ctrl_s     = wr_s && (address == 2'd1);
    assign wr_rate_s     = wr_s && (address == 2'd2);
    assign wr_status_s   = wr_s && (address == 2'd3);
    assign enter_scan_s  = wr_ctrl_s && (writedata[1:0] == MODE_SCAN)  && (mode_q != MODE_SCAN);
    assign enter_blink_s = wr_ctrl_s && (writedata[1:0] == MODE_BLINK) && (mode_q != MODE_BLINK);
    assign scan_pat_s    = NUM_LEDS'(1) << pos_q;
    assign unused_wdata_s = &{1'b0, writedata};
    assign out_port      = out_q;

    // Register-file writes and the shared tick prescaler.
    always_comb begin
        data_d  = data_q;
        mode_d  = mode_q;
        rate_d  = rate_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (wr_data_s) data_d = writedata[NUM_LEDS-1:0];
        else           data_d = data_q;
        if (wr_ctrl_s) mode_d = writedata[1:0];
        else           mode_d = mode_q;
        if (wr_rate_s) rate_d = writedata[RATE_W-1:0];
        else           rate_d = rate_q;
        // A STATUS write reloads without ticking, so the first tick lands RATE+1 cycles later.
        if (wr_status_s) begin
            presc_d = rate_q;
            tick_d  = 1'b0;
        end else if (presc_q == RATE_ZERO) begin
            presc_d = rate_q;
            tick_d  = 1'b1;
        end else begin
            presc_d = presc_q - RATE_ONE;
            tick_d  = 1'b0;
        end
    end

    // Voice stretch counters, blink phase and the output source mux.
    always_comb begin
        cnt_d = cnt_q;
        lit_s = '0;
        out_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (voice_gate[i])                       cnt_d[i] = CNT_LOAD;
            else if (tick_q && (cnt_q[i] != CNT_ZERO)) cnt_d[i] = cnt_q[i] - CNT_ONE;
            else                                     cnt_d[i] = cnt_q[i];
            lit_s[i] = voice_gate[i] | (cnt_q[i] != CNT_ZERO);
        end
        if (enter_blink_s) blink_d = 1'b0;
        else if (tick_q)   blink_d = ~blink_q;
        else               blink_d = blink_q;
        case (mode_q)
            MODE_CPU:   out_d = data_q;
            MODE_VOICE: out_d = lit_s;
            MODE_SCAN:  out_d = scan_pat_s;
            MODE_BLINK: out_d = blink_q ? data_q : '0;
            default:    out_d = '0;
        endcase
    end

    // Scanner next state; a restart wins over a coincident tick.
    always_comb begin
        scan_dir_d = scan_dir_q;
        pos_d      = pos_q;
        if (enter_scan_s || wr_status_s) begin
            scan_dir_d = SCAN_UP;
            pos_d      = POS_ZERO;
        end else if (tick_q) begin
            case (scan_dir_q)
                SCAN_UP: begin
                    pos_d = pos_q + POS_ONE;
                    if (pos_q == POS_LAST - POS_ONE) scan_dir_d = SCAN_DOWN;
                    else                             scan_dir_d = SCAN_UP;
                end
                SCAN_DOWN: begin
                    pos_d = pos_q - POS_ONE;
                    if (pos_q == POS_ONE) scan_dir_d = SCAN_UP;
                    else                  scan_dir_d = SCAN_DOWN;
                end
                default: begin
                    scan_dir_d = SCAN_UP;
                    pos_d      = POS_ZERO;
                end
            endcase
        end else begin
            scan_dir_d = scan_dir_q;
            pos_d      = pos_q;
        end
    end

    // Scanner state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_dir_q <= SCAN_UP;
            pos_q      <= POS_ZERO;
        end else begin
            scan_dir_q <= scan_dir_d;
            pos_q      <= pos_d;
        end
    end

    // Registers, prescaler, counters and the LED output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            mode_q  <= MODE_CPU;
            rate_q  <= RATE_RESET;
            presc_q <= RATE_RESET;
            tick_q  <= 1'b0;
            blink_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            data_q  <= data_d;
            mode_q  <= mode_d;
            rate_q  <= rate_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Zero-latency read mux; unused bits read as zero.
    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata[NUM_LEDS-1:0] = data_q;
            2'd1:    readdata[1:0]          = mode_q;
            2'd2:    readdata[RATE_W-1:0]   = rate_q;
            2'd3:    readdata[NUM_LEDS-1:0] = out_q;
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_led_display_sequencer.sv
// Directed self-checking bench for led_display_sequencer.
module tb_led_display_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [13:0] voice_gate;
    logic [13:0] out_port;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] rd_val;
    logic [31:0] scan_exp [28];
    int          hi_cnt;

    led_display_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .voice_gate (voice_gate),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 14; i++) scan_exp[i] = 32'd1 << i;
        for (int i = 0; i < 13; i++) scan_exp[14 + i] = 32'd1 << (12 - i);
        scan_exp[27] = 32'd2;

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        voice_gate = 14'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        check("rst_out", 32'(out_port), 32'h0);
        rd(2'd0, rd_val); check("rst_data", rd_val, 32'd0);
        rd(2'd1, rd_val); check("rst_ctrl", rd_val, 32'd0);
        rd(2'd2, rd_val); check("rst_rate", rd_val, 32'd49999);
        rd(2'd3, rd_val); check("rst_status", rd_val, 32'd0);

        // CPU mode data path
        wr(2'd0, 32'h2A5A);
        check("cpu_pre", 32'(out_port), 32'h0);
        step(); step();
        check("cpu_out", 32'(out_port), 32'h2A5A);
        rd(2'd0, rd_val); check("cpu_rd_data", rd_val, 32'h2A5A);
        rd(2'd3, rd_val); check("cpu_rd_status", rd_val, 32'h2A5A);

        // Full scan sweep at one tick per clock
        wr(2'd2, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd2);
        for (int k = 0; k < 28; k++) begin
            step();
            check($sformatf("scan_%0d", k), 32'(out_port), scan_exp[k]);
        end
        rd(2'd1, rd_val); check("scan_rd_ctrl", rd_val, 32'd2);
        rd(2'd2, rd_val); check("scan_rd_rate", rd_val, 32'd0);

        // STATUS write restarts the scanner at p=7
        wr(2'd1, 32'd0);
        wr(2'd1, 32'd2);
        repeat (7) step();
        check("restart_p6", 32'(out_port), 32'h0040);
        wr(2'd3, 32'hDEAD);
        check("restart_p7", 32'(out_port), 32'h0080);
        step(); check("restart_a", 32'(out_port), 32'h0001);
        step(); check("restart_b", 32'(out_port), 32'h0001);
        step(); check("restart_c", 32'(out_port), 32'h0002);
        step(); check("restart_d", 32'(out_port), 32'h0004);

        // Voice stretch: one-clock gate on LED 5, RATE=3
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd1);
        @(negedge clk);
        voice_gate = 14'h0020;
        hi_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (i == 0) voice_gate = 14'd0;
            if (out_port[5]) hi_cnt++;
        end
        check("voice_len", 32'(hi_cnt), 32'd32);
        check("voice_off", 32'(out_port), 32'h0);

        // Blink at RATE=1: two clocks dark, two clocks lit
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h00FF);
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd3);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("blink_%0d", k), 32'(out_port), (((k >> 1) & 1) != 0) ? 32'h00FF : 32'h0);
        end
        wr(2'd1, 32'd0);
        step(); step();
        check("cpu_after_blink_a", 32'(out_port), 32'h00FF);
        repeat (5) step();
        check("cpu_after_blink_b", 32'(out_port), 32'h00FF);

        // Asynchronous reset in the middle of a scan
        wr(2'd1, 32'd2);
        repeat (5) step();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out_port), 32'h0);
        rd(2'd0, rd_val); check("async_rst_data", rd_val, 32'd0);
        rd(2'd1, rd_val); check("async_rst_ctrl", rd_val, 32'd0);
        rd(2'd2, rd_val); check("async_rst_rate", rd_val, 32'd49999);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
